// File: rtl/vending_pkg.sv
// Shared types and helpers for the multi-product vending controller:
// FSM/error encodings, accepted coin denominations and price lookup.
package vending_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_SOLD_OUT = 2'd1,
        ERR_INSUFF   = 2'd2
    } err_t;

    localparam int MAX_PRODUCTS = 15;
    localparam int PRICE_VEC_W  = 8 * MAX_PRODUCTS;
    localparam int NUM_DENOMS   = 6;

    localparam logic [NUM_DENOMS-1:0][7:0] COIN_DENOMS = {
        8'd200, 8'd100, 8'd50, 8'd20, 8'd10, 8'd5
    };

    function automatic logic is_valid_coin(input logic [7:0] value);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_DENOMS; i++) begin
            if (value == COIN_DENOMS[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Product numbering starts at 1; index 0 (no product) prices at zero.
    function automatic logic [7:0] price_of(input logic [PRICE_VEC_W-1:0] prices,
                                            input logic [3:0]             idx);
        logic [7:0] price;
        price = 8'd0;
        for (int i = 1; i <= MAX_PRODUCTS; i++) begin
            if (idx == 4'(i)) begin
                price = prices[(i-1)*8 +: 8];
            end
        end
        return price;
    endfunction

endpackage

// File: rtl/vending_stock.sv
// Per-product stock counters with decrement-on-vend, restock to the initial
// level, and a registered sold-out flag per product.
module vending_stock
    import vending_pkg::*;
#(
    parameter int NUM_PRODUCTS = 4,
    parameter int STOCK_W      = 4,
    parameter int INIT_STOCK   = 2,
    parameter int PROD_W       = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dec_valid,
    input  logic [PROD_W-1:0]       dec_idx,
    input  logic                    refill_valid,
    input  logic [PROD_W-1:0]       refill_idx,
    output logic [NUM_PRODUCTS-1:0] sold_out
);

    generate
        for (genvar gi = 0; gi < NUM_PRODUCTS; gi++) begin : g_stock
            logic [STOCK_W-1:0] stock_reg;
            logic [STOCK_W-1:0] stock_next;
            logic               sold_out_reg;

            // The zero guard keeps the counter from wrapping even if a
            // decrement ever arrives for an empty slot.
            always_comb begin
                stock_next = stock_reg;
                if (refill_valid && (refill_idx == PROD_W'(gi + 1))) begin
                    stock_next = STOCK_W'(INIT_STOCK);
                end else if (dec_valid && (dec_idx == PROD_W'(gi + 1)) &&
                             (stock_reg != '0)) begin
                    stock_next = stock_reg - STOCK_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    stock_reg    <= STOCK_W'(INIT_STOCK);
                    sold_out_reg <= (INIT_STOCK == 0);
                end else begin
                    stock_reg    <= stock_next;
                    sold_out_reg <= (stock_next == '0);
                end
            end

            assign sold_out[gi] = sold_out_reg;
        end
    endgenerate

endmodule

// File: rtl/vending_ctrl_multi.sv
// N-product vending controller: coin credit, priced selection with stock and
// credit checks, multi-cycle dispense, change/refund and error pulses.
module vending_ctrl_multi
    import vending_pkg::*;
#(
    parameter int                        NUM_PRODUCTS = 4,
    parameter int                        CREDIT_W     = 10,
    parameter logic [8*NUM_PRODUCTS-1:0] PRICES       = {8'd200, 8'd120, 8'd100, 8'd50},
    parameter int                        MAX_CREDIT   = 500,
    parameter int                        STOCK_W      = 4,
    parameter int                        INIT_STOCK   = 2,
    parameter int                        VEND_CYCLES  = 3,
    localparam int                       PROD_W       = $clog2(NUM_PRODUCTS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    coin_valid,
    input  logic [7:0]              coin_in,
    input  logic [PROD_W-1:0]       button_in,
    input  logic                    cancel_in,
    input  logic                    refill_valid,
    input  logic [PROD_W-1:0]       refill_idx,
    output logic [CREDIT_W-1:0]     credit_out,
    output logic [PROD_W-1:0]       beverage_out,
    output logic                    beverage_valid,
    output logic [CREDIT_W-1:0]     change_out,
    output logic                    change_valid,
    output logic                    coin_reject,
    output logic [1:0]              err_out,
    output logic [NUM_PRODUCTS-1:0] sold_out,
    output logic                    busy
);

    // One spare bit so credit + coin never wraps before the ceiling compare.
    localparam int SUM_W = ((CREDIT_W > 8) ? CREDIT_W : 8) + 1;
    localparam int CNT_W = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;
    localparam logic [PRICE_VEC_W-1:0] PRICES_EXT = PRICE_VEC_W'(PRICES);

    state_t              state_reg, state_next;
    logic [CREDIT_W-1:0] credit_reg, credit_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [PROD_W-1:0]   vend_idx_reg, vend_idx_next;
    logic [PROD_W-1:0]   beverage_reg, beverage_next;
    logic                beverage_valid_reg, beverage_valid_next;
    logic [CREDIT_W-1:0] change_reg, change_next;
    logic                change_valid_reg, change_valid_next;
    logic                coin_reject_reg, coin_reject_next;
    err_t                err_reg, err_next;
    logic                busy_reg;

    logic                    stock_dec;
    logic                    refill_ok;
    logic                    buy_ok;
    logic [NUM_PRODUCTS-1:0] sold_out_vec;
    logic                    button_ok;
    logic                    refill_idx_ok;
    logic                    button_sold_out;
    logic                    coin_ok;
    logic [SUM_W-1:0]        credit_wide;
    logic [SUM_W-1:0]        price_wide;
    logic [SUM_W-1:0]        coin_sum;

    assign button_ok     = (button_in != '0) && (int'(button_in) <= NUM_PRODUCTS);
    assign refill_idx_ok = (refill_idx != '0) && (int'(refill_idx) <= NUM_PRODUCTS);
    assign credit_wide   = SUM_W'(credit_reg);
    assign price_wide    = SUM_W'(price_of(PRICES_EXT, 4'(button_in)));
    assign coin_sum      = credit_wide + SUM_W'(coin_in);
    assign coin_ok       = is_valid_coin(coin_in) && (coin_sum <= SUM_W'(MAX_CREDIT));

    always_comb begin
        button_sold_out = 1'b0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (int'(button_in) == i + 1) begin
                button_sold_out = sold_out_vec[i];
            end
        end
    end

    vending_stock #(
        .NUM_PRODUCTS (NUM_PRODUCTS),
        .STOCK_W      (STOCK_W),
        .INIT_STOCK   (INIT_STOCK),
        .PROD_W       (PROD_W)
    ) u_stock (
        .clk          (clk),
        .rst          (rst),
        .dec_valid    (stock_dec),
        .dec_idx      (vend_idx_reg),
        .refill_valid (refill_ok),
        .refill_idx   (refill_idx),
        .sold_out     (sold_out_vec)
    );

    always_comb begin
        state_next          = state_reg;
        credit_next         = credit_reg;
        cnt_next            = cnt_reg;
        vend_idx_next       = vend_idx_reg;
        beverage_valid_next = 1'b0;
        beverage_next       = '0;
        change_valid_next   = 1'b0;
        change_next         = '0;
        coin_reject_next    = 1'b0;
        err_next            = ERR_NONE;
        stock_dec           = 1'b0;
        refill_ok           = 1'b0;
        buy_ok              = 1'b0;

        case (state_reg)
            ST_IDLE, ST_CREDIT: begin
                refill_ok = refill_valid && refill_idx_ok;
                if (cancel_in && (state_reg == ST_CREDIT)) begin
                    state_next        = ST_CHANGE;
                    change_valid_next = 1'b1;
                    change_next       = credit_reg;
                    credit_next       = '0;
                    coin_reject_next  = coin_valid;
                end else begin
                    if (button_ok) begin
                        if (button_sold_out) begin
                            err_next = ERR_SOLD_OUT;
                        end else if (credit_wide < price_wide) begin
                            err_next = ERR_INSUFF;
                        end else begin
                            buy_ok        = 1'b1;
                            state_next    = ST_VEND;
                            credit_next   = CREDIT_W'(credit_wide - price_wide);
                            cnt_next      = CNT_W'(VEND_CYCLES - 1);
                            vend_idx_next = button_in;
                        end
                    end
                    // A coin only counts when no purchase consumed this cycle.
                    if (coin_valid) begin
                        if (!buy_ok && coin_ok) begin
                            credit_next = CREDIT_W'(coin_sum);
                            state_next  = ST_CREDIT;
                        end else begin
                            coin_reject_next = 1'b1;
                        end
                    end
                end
            end

            ST_VEND: begin
                coin_reject_next = coin_valid;
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else begin
                    stock_dec = 1'b1;
                    if (credit_reg != '0) begin
                        state_next        = ST_CHANGE;
                        change_valid_next = 1'b1;
                        change_next       = credit_reg;
                        credit_next       = '0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end

            ST_CHANGE: begin
                coin_reject_next = coin_valid;
                state_next       = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Dispense pulse is aligned with the final cycle spent in VEND.
        if ((state_next == ST_VEND) && (cnt_next == '0)) begin
            beverage_valid_next = 1'b1;
            beverage_next       = vend_idx_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg          <= ST_IDLE;
            credit_reg         <= '0;
            cnt_reg            <= '0;
            vend_idx_reg       <= '0;
            beverage_reg       <= '0;
            beverage_valid_reg <= 1'b0;
            change_reg         <= '0;
            change_valid_reg   <= 1'b0;
            coin_reject_reg    <= 1'b0;
            err_reg            <= ERR_NONE;
            busy_reg           <= 1'b0;
        end else begin
            state_reg          <= state_next;
            credit_reg         <= credit_next;
            cnt_reg            <= cnt_next;
            vend_idx_reg       <= vend_idx_next;
            beverage_reg       <= beverage_next;
            beverage_valid_reg <= beverage_valid_next;
            change_reg         <= change_next;
            change_valid_reg   <= change_valid_next;
            coin_reject_reg    <= coin_reject_next;
            err_reg            <= err_next;
            busy_reg           <= (state_next == ST_VEND) || (state_next == ST_CHANGE);
        end
    end

    assign credit_out     = credit_reg;
    assign beverage_out   = beverage_reg;
    assign beverage_valid = beverage_valid_reg;
    assign change_out     = change_reg;
    assign change_valid   = change_valid_reg;
    assign coin_reject    = coin_reject_reg;
    assign err_out        = err_reg;
    assign sold_out       = sold_out_vec;
    assign busy           = busy_reg;

endmodule
